// File: rtl/host_write_framer_pkg.sv
// Shared constants for the host write framer: bus widths, frame layout and FSM encoding.
// Error-counter defaults also live here.
package host_write_framer_pkg;

    localparam int W_HOST    = 16;
    localparam int W_WR_ADDR = W_HOST;
    localparam int W_WR_CHAN = W_HOST;
    localparam int W_WR_DATA = 3 * W_HOST;
    localparam int N_CHAN    = 5;
    localparam int FRAME_LEN = 6;
    localparam int TIMEOUT   = 1024;
    localparam int WR_GAP    = 2;
    localparam int W_ERR     = 8;

    localparam logic [W_HOST-1:0] SYNC_WORD  = 16'hC0DE;
    localparam logic [W_HOST-1:0] BCAST_CHAN = '1;

    // One state per frame word, so D0 sits at FRAME_LEN-1 and ISSUE follows it directly.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_CHAN  = 3'd2;
    localparam logic [2:0] ST_D2    = 3'd3;
    localparam logic [2:0] ST_D1    = 3'd4;
    localparam logic [2:0] ST_D0    = 3'(FRAME_LEN - 1);
    localparam logic [2:0] ST_ISSUE = 3'(FRAME_LEN);
    localparam logic [2:0] ST_GAP   = 3'(FRAME_LEN + 1);

endpackage

// File: rtl/host_write_framer_if.sv
// Host word handshake plus the configuration write bus driven into the pipeline.
interface host_write_framer_if;
    import host_write_framer_pkg::*;

    logic                 host_dv_in;
    logic [W_HOST-1:0]    host_data_in;
    logic                 host_rdy_out;
    logic                 wr_en;
    logic [W_WR_ADDR-1:0] wr_addr;
    logic [W_WR_CHAN-1:0] wr_chan;
    logic [W_WR_DATA-1:0] wr_data;

    modport master (
        input  host_dv_in, host_data_in,
        output host_rdy_out, wr_en, wr_addr, wr_chan, wr_data
    );

    modport slave (
        output host_dv_in, host_data_in,
        input  host_rdy_out, wr_en, wr_addr, wr_chan, wr_data
    );

endinterface

// File: rtl/host_write_framer_sat_counter.sv
// Saturating up-counter used for the framer's error statistics; sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && count != '1) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/host_write_framer.sv
// Assembles 6-word host frames (sync, addr, chan, data hi..lo) into single-cycle
// configuration writes, with idle timeout, channel range check and error counters.
module host_write_framer
    import host_write_framer_pkg::*;
#(
    parameter int N_CHAN_P  = N_CHAN,
    parameter int TIMEOUT_P = TIMEOUT,
    parameter int WR_GAP_P  = WR_GAP
) (
    input  logic               clk_in,
    input  logic               rst_in,
    host_write_framer_if.master bus,
    output logic               busy_out,
    output logic [W_ERR-1:0]   err_sync_out,
    output logic [W_ERR-1:0]   err_to_out,
    output logic [W_ERR-1:0]   err_chan_out
);

    localparam int W_TO  = $clog2(TIMEOUT_P);
    localparam int W_GAP = (WR_GAP_P > 1) ? $clog2(WR_GAP_P) : 1;

    logic [2:0]        state, state_nx;
    logic [W_HOST-1:0] sh_addr, sh_chan, sh_d2, sh_d1;
    logic [W_TO-1:0]   idle_cnt;
    logic [W_GAP-1:0]  gap_cnt;

    logic accept, in_frame, timeout, chan_ok, issue_now;
    logic inc_sync, inc_to, inc_chan;

    assign accept    = bus.host_dv_in & bus.host_rdy_out;
    assign in_frame  = (state >= ST_ADDR) && (state <= ST_D0);
    // An accepted word in the expiry cycle takes priority over the abort.
    assign timeout   = in_frame && !accept && (idle_cnt == W_TO'(TIMEOUT_P - 1));
    assign chan_ok   = (sh_chan < W_HOST'(N_CHAN_P)) || (sh_chan == BCAST_CHAN);
    assign issue_now = (state == ST_D0) && accept;

    assign inc_sync  = (state == ST_IDLE) && accept && (bus.host_data_in != SYNC_WORD);
    assign inc_to    = timeout;
    assign inc_chan  = issue_now && !chan_ok;
    assign busy_out  = (state != ST_IDLE);

    // NOTE: every variable in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept && bus.host_data_in == SYNC_WORD) state_nx = ST_ADDR;
            end
            ST_ADDR, ST_CHAN, ST_D2, ST_D1, ST_D0: begin
                if (accept)       state_nx = state + 3'd1;
                else if (timeout) state_nx = ST_IDLE;
            end
            ST_ISSUE: state_nx = (WR_GAP_P == 0) ? ST_IDLE : ST_GAP;
            ST_GAP: begin
                if (int'(gap_cnt) == WR_GAP_P - 1) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= ST_IDLE;
            bus.host_rdy_out <= 1'b0;
            bus.wr_en        <= 1'b0;
            bus.wr_addr      <= '0;
            bus.wr_chan      <= '0;
            bus.wr_data      <= '0;
            sh_addr          <= '0;
            sh_chan          <= '0;
            sh_d2            <= '0;
            sh_d1            <= '0;
            idle_cnt         <= '0;
            gap_cnt          <= '0;
        end else begin
            state            <= state_nx;
            bus.host_rdy_out <= !(state_nx == ST_ISSUE || state_nx == ST_GAP);
            bus.wr_en        <= issue_now && chan_ok;

            if (accept) begin
                case (state)
                    ST_ADDR: sh_addr <= bus.host_data_in;
                    ST_CHAN: sh_chan <= bus.host_data_in;
                    ST_D2:   sh_d2   <= bus.host_data_in;
                    ST_D1:   sh_d1   <= bus.host_data_in;
                    default: ;
                endcase
            end

            // Outputs load straight off the D0 transfer so the strobe lands in the ISSUE cycle.
            if (issue_now && chan_ok) begin
                bus.wr_addr <= sh_addr;
                bus.wr_chan <= sh_chan;
                bus.wr_data <= {sh_d2, sh_d1, bus.host_data_in};
            end

            idle_cnt <= (accept || !in_frame) ? '0 : idle_cnt + W_TO'(1);
            gap_cnt  <= (state == ST_GAP) ? gap_cnt + W_GAP'(1) : '0;
        end
    end

    sat_counter #(.W(W_ERR)) u_err_sync (
        .clk(clk_in), .rst_n(rst_in), .inc(inc_sync), .clear(1'b0), .count(err_sync_out)
    );

    sat_counter #(.W(W_ERR)) u_err_to (
        .clk(clk_in), .rst_n(rst_in), .inc(inc_to), .clear(1'b0), .count(err_to_out)
    );

    sat_counter #(.W(W_ERR)) u_err_chan (
        .clk(clk_in), .rst_n(rst_in), .inc(inc_chan), .clear(1'b0), .count(err_chan_out)
    );

endmodule

// File: tb/tb_host_write_framer.sv
// Directed bench for host_write_framer: a table of frames with hand-computed results,
// then hand-written sequences for sync errors, timeout, saturation and reset mid-frame.
module tb_host_write_framer;
    import host_write_framer_pkg::*;

    typedef struct {
        logic [15:0] w [6];
        bit          en;
        logic [15:0] addr;
        logic [15:0] chan;
        logic [47:0] data;
        logic [7:0]  err_chan;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [7:0] err_sync, err_to, err_chan;

    host_write_framer_if bus ();

    host_write_framer dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .bus          (bus),
        .busy_out     (busy),
        .err_sync_out (err_sync),
        .err_to_out   (err_to),
        .err_chan_out (err_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int pulse_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) pulse_q.push_back(cyc);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic send(input logic [15:0] w, input bit keep);
        int n;
        n = 0;
        @(negedge clk);
        bus.host_dv_in   = 1'b1;
        bus.host_data_in = w;
        while (bus.host_rdy_out !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.host_rdy_out !== 1'b1) check("send_rdy_timeout", 64'(bus.host_rdy_out), 64'd1);
        @(posedge clk);
        #1;
        if (!keep) bus.host_dv_in = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] w [6], input bit keep);
        for (int i = 0; i < 6; i++) send(w[i], keep);
    endtask

    // Counts rdy-low cycles from the current cycle until the framer is ready again.
    task automatic wait_idle(output int lows);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.host_rdy_out === 1'b1) break;
            lows++;
        end
        if (bus.host_rdy_out !== 1'b1) check("wait_idle_timeout", 64'(bus.host_rdy_out), 64'd1);
    endtask

    function automatic vec_t mk(input logic [15:0] a, c, d2, d1, d0, input bit en,
                                input logic [15:0] ea, ec, input logic [47:0] ed,
                                input logic [7:0] eerr);
        vec_t v;
        v.w[0] = SYNC_WORD; v.w[1] = a; v.w[2] = c;
        v.w[3] = d2; v.w[4] = d1; v.w[5] = d0;
        v.en = en; v.addr = ea; v.chan = ec; v.data = ed; v.err_chan = eerr;
        return v;
    endfunction

    vec_t        tbl [6];
    logic [15:0] fw [6];
    int          lows, p0, min_gap;
    logic [15:0] c;

    initial begin
        tbl[0] = mk(16'h0003, 16'h0002, 16'h0000, 16'h0001, 16'h0002, 1'b1,
                    16'h0003, 16'h0002, 48'h0000_0001_0002, 8'd0);
        tbl[1] = mk(16'h00AA, 16'h0007, 16'h1111, 16'h2222, 16'h3333, 1'b0,
                    16'h0003, 16'h0002, 48'h0000_0001_0002, 8'd1);
        tbl[2] = mk(16'h0055, 16'hFFFF, 16'hDEAD, 16'hBEEF, 16'hCAFE, 1'b1,
                    16'h0055, 16'hFFFF, 48'hDEAD_BEEF_CAFE, 8'd1);
        tbl[3] = mk(16'h0010, 16'h0004, 16'hC0DE, 16'h0000, 16'h0001, 1'b1,
                    16'h0010, 16'h0004, 48'hC0DE_0000_0001, 8'd1);
        tbl[4] = mk(16'h0020, 16'h0005, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0,
                    16'h0010, 16'h0004, 48'hC0DE_0000_0001, 8'd2);
        tbl[5] = mk(16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 1'b1,
                    16'h0000, 16'h0000, 48'h8000_0000_0000, 8'd2);

        rst_n = 1'b0;
        bus.host_dv_in = 1'b0;
        bus.host_data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 64'(bus.host_rdy_out), 64'd0);
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_data", 64'(bus.wr_data), 64'd0);
        check("rst_errs", {40'd0, err_sync, err_to, err_chan}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rdy_before_first_clk", 64'(bus.host_rdy_out), 64'd0);
        @(posedge clk);
        #1 check("rdy_first_clk", 64'(bus.host_rdy_out), 64'd1);

        for (int i = 0; i < 6; i++) begin
            p0 = pulse_q.size();
            send_frame(tbl[i].w, 1'b0);
            check($sformatf("v%0d_wr_en", i), 64'(bus.wr_en), 64'(tbl[i].en));
            check($sformatf("v%0d_addr", i), 64'(bus.wr_addr), 64'(tbl[i].addr));
            check($sformatf("v%0d_chan", i), 64'(bus.wr_chan), 64'(tbl[i].chan));
            check($sformatf("v%0d_data", i), 64'(bus.wr_data), 64'(tbl[i].data));
            check($sformatf("v%0d_err_chan", i), 64'(err_chan), 64'(tbl[i].err_chan));
            wait_idle(lows);
            check($sformatf("v%0d_rdy_low", i), 64'(lows), 64'd3);
            check($sformatf("v%0d_pulses", i), 64'(pulse_q.size() - p0), 64'(tbl[i].en));
        end

        // Garbage words before sync are discarded and counted.
        send(16'h1234, 1'b0);
        send(16'h5678, 1'b0);
        check("err_sync_2", 64'(err_sync), 64'd2);
        check("idle_after_junk", 64'(busy), 64'd0);
        fw = '{SYNC_WORD, 16'h0001, 16'h0004, 16'h0000, 16'h0000, 16'h0000};
        send_frame(fw, 1'b0);
        check("sync_err_frame_en", 64'(bus.wr_en), 64'd1);
        check("sync_err_frame_chan", 64'(bus.wr_chan), 64'd4);
        check("err_sync_held", 64'(err_sync), 64'd2);
        wait_idle(lows);

        // A word arriving in the last idle cycle before expiry is accepted.
        send(SYNC_WORD, 1'b0);
        send(16'h0009, 1'b0);
        repeat (1023) @(posedge clk);
        #1;
        check("to_edge_busy", 64'(busy), 64'd1);
        check("to_edge_err_to", 64'(err_to), 64'd0);
        send(16'h0001, 1'b0);
        send(16'h0000, 1'b0);
        send(16'h0000, 1'b0);
        send(16'h0007, 1'b0);
        check("to_win_en", 64'(bus.wr_en), 64'd1);
        check("to_win_addr", 64'(bus.wr_addr), 64'h0009);
        check("to_win_err_to", 64'(err_to), 64'd0);
        wait_idle(lows);

        // A full 1024 idle cycles abort the frame.
        p0 = pulse_q.size();
        send(SYNC_WORD, 1'b0);
        send(16'h000A, 1'b0);
        repeat (1023) @(posedge clk);
        #1 check("to_pre_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        check("to_abort_busy", 64'(busy), 64'd0);
        check("to_abort_err_to", 64'(err_to), 64'd1);
        check("to_abort_addr_kept", 64'(bus.wr_addr), 64'h0009);
        check("to_abort_pulses", 64'(pulse_q.size() - p0), 64'd0);
        fw = '{SYNC_WORD, 16'h000B, 16'h0003, 16'h0001, 16'h0002, 16'h0003};
        send_frame(fw, 1'b0);
        check("after_to_en", 64'(bus.wr_en), 64'd1);
        check("after_to_data", 64'(bus.wr_data), 64'h0001_0002_0003);
        wait_idle(lows);

        // 300 frames with dv held high: 13 of every 15 carry an illegal channel.
        p0 = pulse_q.size();
        for (int i = 0; i < 300; i++) begin
            if (i % 15 < 13)       c = 16'(5 + i % 15);
            else if (i % 15 == 13) c = 16'h0000;
            else                   c = 16'hFFFF;
            fw = '{SYNC_WORD, 16'(i), c, 16'(i), 16'hA5A5, 16'(i)};
            send_frame(fw, 1'b1);
        end
        bus.host_dv_in = 1'b0;
        wait_idle(lows);
        check("sat_err_chan", 64'(err_chan), 64'd255);
        check("sat_pulses", 64'(pulse_q.size() - p0), 64'd40);
        min_gap = 1_000_000;
        for (int j = p0 + 1; j < pulse_q.size(); j++) begin
            if (pulse_q[j] - pulse_q[j-1] < min_gap) min_gap = pulse_q[j] - pulse_q[j-1];
        end
        check("sat_min_pulse_gap", 64'(min_gap), 64'd9);
        check("sat_last_addr", 64'(bus.wr_addr), 64'h012B);
        check("sat_last_chan", 64'(bus.wr_chan), 64'hFFFF);
        check("sat_last_data", 64'(bus.wr_data), 64'h012B_A5A5_012B);

        // Reset after the D1 word loses the frame.
        p0 = pulse_q.size();
        send(SYNC_WORD, 1'b0);
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b0);
        send(16'h0004, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("mid_rst_outs", 64'(bus.wr_addr) | 64'(bus.wr_chan) | 64'(bus.wr_data), 64'd0);
        check("mid_rst_busy_rdy", {62'd0, busy, bus.host_rdy_out}, 64'd0);
        check("mid_rst_errs", {40'd0, err_sync, err_to, err_chan}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_rdy_first_clk", 64'(bus.host_rdy_out), 64'd1);
        repeat (3) @(posedge clk);
        #1 check("mid_rst_pulses", 64'(pulse_q.size() - p0), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/host_write_framer.md
Name: host_write_framer

Overview:
- Initiator side of the pipeline configuration write bus (wr_en/wr_addr/wr_chan/wr_data).
- Consumes a 16-bit host word stream with a valid/ready handshake and assembles fixed 6-word frames: sync, addr, chan, data[47:32], data[31:16], data[15:0].
- Issues one single-cycle write strobe per valid frame into the PID pipeline, shared by dispatch, oversample, PID and output filters.
- Provides timeout recovery, channel range checking and saturating error counters.

Parameters:
- W_HOST, 16, host word width
- W_WR_ADDR, 16, write address width; must equal W_HOST
- W_WR_CHAN, 16, write channel width; must equal W_HOST
- W_WR_DATA, 48, write data width; must equal 3*W_HOST
- N_CHAN, 5, number of valid pipeline channels
- SYNC_WORD, 16'hC0DE, frame header
- TIMEOUT, 1024, max idle cycles between words inside a frame
- WR_GAP, 2, dead cycles after each issue
- W_ERR, 8, error counter width

Ports:
- clk_in, in, 1, system clock
- rst_in, in, 1, reset, asynchronous, active-low
- host_dv_in, in, 1, host word valid
- host_data_in, in, W_HOST, host word
- host_rdy_out, out, 1, framer ready; a word transfers when host_dv_in & host_rdy_out
- wr_en, out, 1, single-cycle write strobe
- wr_addr, out, W_WR_ADDR, write address
- wr_chan, out, W_WR_CHAN, write channel
- wr_data, out, W_WR_DATA, write data
- busy_out, out, 1, high whenever state != IDLE
- err_sync_out, out, W_ERR, count of non-sync words discarded in IDLE
- err_to_out, out, W_ERR, count of frames aborted by timeout
- err_chan_out, out, W_ERR, count of frames dropped for bad channel

Behaviour:
- Reset (rst_in low, async): state=IDLE; wr_en=0; wr_addr/wr_chan/wr_data=0; all error counters=0; host_rdy_out=0; busy_out=0.
- host_rdy_out is registered: 1 in IDLE, ADDR, CHAN, D2, D1, D0; 0 in ISSUE and GAP. It rises the first clock after reset release.
- Shadow registers capture fields as they arrive. wr_addr/wr_chan/wr_data update only at ISSUE with a legal channel, and hold until the next issue.
- FSM, advancing on each accepted word:
  - IDLE: word == SYNC_WORD -> ADDR. Any other word is discarded and err_sync increments.
  - ADDR -> CHAN -> D2 -> D1 -> D0 -> ISSUE. Words are stored MSB-first. A SYNC_WORD value arriving mid-frame is ordinary data; there is no resync.
  - ISSUE (1 cycle):
    - If chan < N_CHAN or chan == all-ones (broadcast): load the outputs and pulse wr_en.
    - Otherwise: no wr_en, outputs unchanged, err_chan increments.
    - Either way -> GAP.
  - GAP: WR_GAP cycles with rdy=0, then -> IDLE. If WR_GAP == 0, ISSUE -> IDLE directly.
- Latency: wr_en and the new field values are visible the first cycle after the D0 word transfers.
- Timeout:
  - The idle counter clears on every accepted word and on entry to ADDR.
  - In ADDR..D0, reaching TIMEOUT cycles with no accepted word -> IDLE and err_to increments.
  - The frame is discarded; outputs are unchanged.
  - A word offered in the same cycle the timeout fires is accepted and wins: no abort.
- Error counters saturate at all-ones and never wrap.
- Async reset mid-frame: the frame is lost, no wr_en is produced, and everything returns to the reset values.
- host_dv_in while host_rdy_out=0: the word is ignored and nothing is counted. The host must hold it.

Decomposition:
- Add SYNC_WORD, the frame length (6) and the broadcast channel constant to parameters.vh, alongside the existing width defines.
- One sub-module, sat_counter (parameter W; inputs inc and clear; output count), instantiated three times for the error counters.
- The FSM and shadow registers stay in host_write_framer.

Test Plan:
- Frame C0DE,0003,0002,0000,0001,0002 back-to-back -> a single wr_en pulse on the next cycle with wr_addr=0003, wr_chan=0002, wr_data=48'h000000010002. host_rdy_out is low for 3 cycles (ISSUE + 2 GAP), then high.
- Words 1234, 5678 then a valid frame (addr 0001, chan 0004, data all zero) -> err_sync=2 and one write to chan 4.
- Frame with chan=0007 (N_CHAN=5) -> no wr_en, err_chan=1, outputs retain previous values. A following frame with chan=FFFF is issued as broadcast.
- Send sync+addr, then idle 1024 cycles -> return to IDLE, err_to=1, no wr_en. A subsequent full frame is issued normally.
- Hold host_dv_in high continuously through 300 frames of which 260 have a bad channel -> err_chan saturates at 255, and 40 wr_en pulses occur, each separated by at least the 2 GAP cycles.
- Assert rst_in low after the D1 word -> wr_en never pulses, all outputs are 0. After release, host_rdy_out=1 on the first clock.
